// File: rtl/key_sched_if.sv
// Signal bundle between the key sequencer side and the AES-128 round-key generator.
interface key_sched_if;
   logic [127:0] key_in;
   logic         load_in;
   logic         next_in;
   logic [127:0] round_key_out;
   logic [3:0]   round_out;
   logic         key_valid_out;
   logic         done_out;

   modport master (
      output key_in, load_in, next_in,
      input  round_key_out, round_out, key_valid_out, done_out
   );

   modport slave (
      input  key_in, load_in, next_in,
      output round_key_out, round_out, key_valid_out, done_out
   );
endinterface

// File: rtl/key_sched.sv
// AES-128 on-the-fly round-key generator: one FIPS-197 expansion step per advance,
// only the current round key is held.
//
// state  | meaning
// IDLE   | no key held since reset
// ACTIVE | key for round_out valid, round_out < 10
// DONE   | round-10 key held, advances ignored
module key_sched (
   input  logic        clk,
   input  logic        rst,
   key_sched_if.slave  ks
);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   localparam logic [2047:0] SBOX_FLAT = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX_FLAT[11'd2047 - {a, 3'b000} -: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_t       r_state,  w_state_nxt;
   logic [127:0] r_key,    w_key_nxt;
   logic [3:0]   r_round,  w_round_nxt;
   logic         r_valid,  w_valid_nxt;
   logic         r_done,   w_done_nxt;

   logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_rot, w_t;
   logic [31:0]  w_n0, w_n1, w_n2, w_n3;
   logic [3:0]   w_round_inc;

   assign w_round_inc = r_round + 4'd1;

   // Single S-box layer straight off the key register.
   assign {w_w0, w_w1, w_w2, w_w3} = r_key;
   assign w_rot = {w_w3[23:0], w_w3[31:24]};
   assign w_t   = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
                  ^ {rcon(w_round_inc), 24'h0};
   assign w_n0  = w_w0 ^ w_t;
   assign w_n1  = w_w1 ^ w_n0;
   assign w_n2  = w_w2 ^ w_n1;
   assign w_n3  = w_w3 ^ w_n2;

   always_comb begin
      w_state_nxt = r_state;
      w_key_nxt   = r_key;
      w_round_nxt = r_round;
      w_valid_nxt = r_valid;
      w_done_nxt  = r_done;
      if (ks.load_in) begin
         w_state_nxt = ACTIVE;
         w_key_nxt   = ks.key_in;
         w_round_nxt = 4'd0;
         w_valid_nxt = 1'b1;
         w_done_nxt  = 1'b0;
      end else if (r_state == ACTIVE && ks.next_in) begin
         w_key_nxt   = {w_n0, w_n1, w_n2, w_n3};
         w_round_nxt = w_round_inc;
         if (w_round_inc == 4'd10) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_key   <= '0;
         r_round <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_key   <= w_key_nxt;
         r_round <= w_round_nxt;
         r_valid <= w_valid_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign ks.round_key_out = r_key;
   assign ks.round_out     = r_round;
   assign ks.key_valid_out = r_valid;
   assign ks.done_out      = r_done;

endmodule

// File: tb/tb_key_sched.sv
// Bench for key_sched: reference schedule built from GF(2^8) arithmetic and the FIPS-197 word recurrence.
module tb_key_sched;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   key_sched_if bus ();
   key_sched dut (.clk(clk), .rst(rst), .ks(bus));

   localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K_ZERO = 128'h000102030405060708090a0b0c0d0e0f;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]   sb [256];
   logic [127:0] mk [11];

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, b;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
         b = inv;
         sb[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   task automatic build_model(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic cyc(input logic ld, input logic nx, input logic [127:0] k);
      bus.load_in = ld;
      bus.next_in = nx;
      bus.key_in  = k;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.load_in = 1'b0; bus.next_in = 1'b0; bus.key_in = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out} !== 134'b0) begin
         n_fail++;
         $display("FAIL reset_state: got key=%h rnd=%0d v=%b d=%b, need all zero",
                  bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out);
      end
      rst = 1'b1;
      cyc(1'b1, 1'b0, K_FIPS);
      cyc(1'b0, 1'b1, '0);
      cyc(1'b0, 1'b1, '0);
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out} !== 134'b0) begin
         n_fail++;
         $display("FAIL reset_async: got key=%h rnd=%0d v=%b d=%b, need all zero",
                  bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out);
      end
      @(negedge clk);
      cyc(1'b0, 1'b1, K_FIPS);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, K_FIPS);
         n_checks++;
         if ({bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out} !== 134'b0) begin
            n_fail++;
            $display("FAIL idle_next_ignored: got key=%h rnd=%0d v=%b d=%b, need all zero",
                     bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out);
         end
      end
   endtask

   task automatic test_round1();
      cyc(1'b1, 1'b0, K_FIPS);
      n_checks++;
      if ({bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out} !== {K_FIPS, 4'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL load_round0: got key=%h rnd=%0d v=%b d=%b, need key=%h rnd=0 v=1 d=0",
                  bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out, K_FIPS);
      end
      cyc(1'b0, 1'b1, '0);
      n_checks++;
      if ({bus.round_key_out, bus.round_out, bus.done_out} !== {128'ha0fafe1788542cb123a339392a6c7605, 4'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL round1_key: got key=%h rnd=%0d d=%b, need a0fafe1788542cb123a339392a6c7605 rnd=1 d=0",
                  bus.round_key_out, bus.round_out, bus.done_out);
      end
   endtask

   task automatic test_full_schedule();
      build_model(K_FIPS);
      cyc(1'b1, 1'b0, K_FIPS);
      for (int r = 1; r <= 10; r++) begin
         cyc(1'b0, 1'b1, $urandom());
         n_checks++;
         if ({bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out} !== {mk[r], 4'(r), 1'b1, r == 10}) begin
            n_fail++;
            $display("FAIL full_round%0d: got key=%h rnd=%0d v=%b d=%b, need key=%h d=%b",
                     r, bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out, mk[r], r == 10);
         end
      end
      n_checks++;
      if ({bus.round_key_out, bus.done_out} !== {128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1}) begin
         n_fail++;
         $display("FAIL round10_key: got key=%h d=%b, need d014f9a8c9ee2589e13f0cc8b6630ca6 d=1",
                  bus.round_key_out, bus.done_out);
      end
      cyc(1'b0, 1'b1, '0);
      n_checks++;
      if ({bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out} !== {mk[10], 4'd10, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL done_hold: got key=%h rnd=%0d v=%b d=%b, need key=%h rnd=10 v=1 d=1",
                  bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out, mk[10]);
      end
   endtask

   task automatic test_gapped();
      build_model(K_FIPS);
      cyc(1'b1, 1'b0, K_FIPS);
      for (int r = 1; r <= 10; r++) begin
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            cyc(1'b0, 1'b0, $urandom());
            n_checks++;
            if ({bus.round_key_out, bus.round_out, bus.done_out} !== {mk[r-1], 4'(r-1), 1'b0}) begin
               n_fail++;
               $display("FAIL gap_hold_r%0d: got key=%h rnd=%0d d=%b, need key=%h",
                        r - 1, bus.round_key_out, bus.round_out, bus.done_out, mk[r-1]);
            end
         end
         cyc(1'b0, 1'b1, '0);
         n_checks++;
         if ({bus.round_key_out, bus.round_out, bus.done_out} !== {mk[r], 4'(r), r == 10}) begin
            n_fail++;
            $display("FAIL gap_round%0d: got key=%h rnd=%0d d=%b, need key=%h",
                     r, bus.round_key_out, bus.round_out, bus.done_out, mk[r]);
         end
      end
   endtask

   task automatic test_load_priority();
      cyc(1'b1, 1'b0, K_FIPS);
      repeat (5) cyc(1'b0, 1'b1, '0);
      cyc(1'b1, 1'b1, K_ZERO);
      n_checks++;
      if ({bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out} !== {K_ZERO, 4'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL load_priority: got key=%h rnd=%0d v=%b d=%b, need key=%h rnd=0 v=1 d=0",
                  bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out, K_ZERO);
      end
      cyc(1'b0, 1'b1, '0);
      n_checks++;
      if ({bus.round_key_out, bus.round_out} !== {128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 4'd1}) begin
         n_fail++;
         $display("FAIL reload_round1: got key=%h rnd=%0d, need d6aa74fdd2af72fadaa678f1d6ab76fe rnd=1",
                  bus.round_key_out, bus.round_out);
      end
   endtask

   task automatic test_reset_mid();
      build_model(K_FIPS);
      cyc(1'b1, 1'b0, K_FIPS);
      repeat (7) cyc(1'b0, 1'b1, '0);
      bus.next_in = 1'b0;
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out} !== 134'b0) begin
         n_fail++;
         $display("FAIL reset_mid_r7: got key=%h rnd=%0d v=%b d=%b, need all zero",
                  bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out);
      end
      @(negedge clk);
      rst = 1'b1;
      cyc(1'b0, 1'b1, K_FIPS);
      n_checks++;
      if ({bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out} !== 134'b0) begin
         n_fail++;
         $display("FAIL post_reset_needs_load: got key=%h rnd=%0d v=%b d=%b, need all zero",
                  bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out);
      end
      cyc(1'b1, 1'b0, K_FIPS);
      for (int r = 1; r <= 10; r++) begin
         cyc(1'b0, 1'b1, '0);
         n_checks++;
         if ({bus.round_key_out, bus.round_out, bus.done_out} !== {mk[r], 4'(r), r == 10}) begin
            n_fail++;
            $display("FAIL reload_round%0d: got key=%h rnd=%0d d=%b, need key=%h",
                     r, bus.round_key_out, bus.round_out, bus.done_out, mk[r]);
         end
      end
   endtask

   task automatic test_random();
      int          mr;
      logic        ld, nx;
      logic [127:0] k;
      mr = 0;
      for (int i = 0; i < 400; i++) begin
         ld = (i == 0) || ($urandom_range(0, 15) == 0);
         nx = 1'($urandom_range(0, 1));
         k  = {$urandom(), $urandom(), $urandom(), $urandom()};
         cyc(ld, nx, k);
         if (ld) begin
            build_model(k);
            mr = 0;
         end else if (nx && mr < 10) begin
            mr++;
         end
         n_checks++;
         if ({bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out} !== {mk[mr], 4'(mr), 1'b1, mr == 10}) begin
            n_fail++;
            $display("FAIL random_cyc%0d: got key=%h rnd=%0d v=%b d=%b, need key=%h rnd=%0d d=%b",
                     i, bus.round_key_out, bus.round_out, bus.key_valid_out, bus.done_out, mk[mr], mr, mr == 10);
         end
      end
   endtask

   initial begin
      build_sbox();
      @(negedge clk);
      test_reset();
      test_round1();
      test_full_schedule();
      test_gapped();
      test_load_priority();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_sched.md
Name: key_sched

Overview:
- AES-128 round-key generator that sits directly upstream of the round-key-add stage.
- Drives that stage's scheduled-key input (ksch_key_in) with round keys 1..10, one round per advance request.
- Loads the 128-bit cipher key, then expands it on the fly, one FIPS-197 expansion step per clock.
- Holds only the current round key; no full key table is stored.

Parameters:
None. AES-128 only: Nk=4, Nr=10, fixed.

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-low reset
key_in  input  128  cipher key; bits [127:96] = word w0, [31:0] = w3
load_in  input  1  load key_in as round-0 key
next_in  input  1  advance to next round key
round_key_out  output  128  current round key; feeds round-add ksch_key_in
round_out  output  4  index of the key on round_key_out, 0..10
key_valid_out  output  1  round_key_out holds a valid key
done_out  output  1  round_out == 10, schedule exhausted

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst). All outputs are registered.
- Reset values: round_key_out=0, round_out=0, key_valid_out=0, done_out=0, state=IDLE.
- States:
  - IDLE: no key held.
  - ACTIVE: key for round_out valid, round_out < 10.
  - DONE: round-10 key held.
- IDLE:
  - load_in=1 -> next cycle: round_key_out=key_in, round_out=0, key_valid_out=1, state ACTIVE.
  - next_in is ignored.
- ACTIVE:
  - next_in=1 -> next cycle: round_key_out=expand(round_key_out, RCON[round_out+1]), round_out incremented. Latency 1 clock; back-to-back next_in is allowed every cycle.
  - If the new round_out is 10 -> state DONE and done_out=1 in the same cycle the round-10 key appears.
- DONE:
  - next_in is ignored; key, round_out and done_out hold.
  - load_in restarts the schedule as in IDLE, with done_out cleared.
- load_in has priority over next_in in every state. Load while mid-schedule discards the current key and restarts at round 0.
- key_valid_out stays 1 from the first load until reset.
- expand(k, rc), with w0..w3 = k[127:96]..k[31:0]:
  - t = SubWord(RotWord(w3)) ^ {rc, 24'h0}
  - RotWord: bytes {a,b,c,d} -> {b,c,d,a}
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2; result {n0,n1,n2,n3}
- SubWord: four AES S-box lookups, implemented as a 256-entry combinational function inside the block.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- The whole expansion step is combinational from registered state: no multicycle paths, one S-box layer.
- Reset asserted mid-schedule: outputs go to reset values immediately (asynchronous). After deassertion a new load_in is required.
- key_in is sampled only in the cycle load_in=1 and may change afterwards.
- Round-0 key equals key_in. The downstream round-add stage uses its own cipher-key input for round 0, so the sequencer asserts next_in before the round-1 add.

Test Plan:
1. Reset/idle: assert rst=0 mid-run, with next_in pulsed while IDLE -> all outputs 0, state stays IDLE.
2. Round 1: load key_in=2b7e151628aed2a6abf7158809cf4f3c, then one next_in -> round_key_out=a0fafe1788542cb123a339392a6c7605, round_out=1.
3. Full schedule: load the same key, then 10 consecutive next_in cycles -> round_out=10, round_key_out=d014f9a8c9ee2589e13f0cc8b6630ca6, done_out=1 on that same cycle. An 11th next_in leaves the key unchanged.
4. Gapped advance: load, then next_in with random idle gaps -> key sequence identical to test 3. Outputs are stable during gaps.
5. Load priority: load_in and next_in together at round 5 with key_in=000102030405060708090a0b0c0d0e0f -> round_out=0, key=key_in, done_out=0. One next_in then gives d6aa74fdd2af72fadaa678f1d6ab76fe.
6. Reset mid-schedule at round 7 -> immediate zero outputs. After reload and 10 advances, the results match test 3.
